alu_iter: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle ALU. It implements the existing

---
 rtl/alu_iter.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_iter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// Iterative, handshaked ALU: single-cycle logic/arithmetic ops, multi-cycle shifts and
// shift-add multiply. Results and flags are registered and held until the consumer takes them.
module alu_iter #(
    parameter int WIDTH      = 8,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             illegal
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] STEP       = CW'(SHIFT_STEP);
    localparam logic [CW-1:0] MUL_CYCLES = CW'(WIDTH);
    localparam logic [CW-1:0] ONE        = CW'(1);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_LSH = 4'h5;
    localparam logic [3:0] OP_RSH = 4'h6;
    localparam logic [3:0] OP_SEQ = 4'h7;
    localparam logic [3:0] OP_SLT = 4'h8;
    localparam logic [3:0] OP_MUL = 4'h9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] work_q,    work_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [CW-1:0]    rem_q,     rem_d;
    logic             shl_q,     shl_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             carry_q,   carry_d;
    logic             zero_q,    zero_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             commit;
    logic             new_carry;
    logic             new_illegal;
    logic [LW-1:0]    amt;
    logic [CW-1:0]    step;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;

    assign accept   = in_valid && in_ready;
    assign amt      = b[LW-1:0];
    assign step     = (rem_q > STEP) ? STEP : rem_q;
    assign add_sum  = {1'b0, a} + {1'b0, b};
    assign sub_diff = {1'b0, a} - {1'b0, b};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d = MUL;
                    end else if ((op == OP_LSH || op == OP_RSH) && amt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT, MUL: begin
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Result and flags only change on "commit", so they stay put while an op is in flight
    always_comb begin
        work_d      = work_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        shl_d       = shl_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        commit      = 1'b0;
        new_carry   = 1'b0;
        new_illegal = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_ADD: begin
                            result_d  = add_sum[WIDTH-1:0];
                            new_carry = add_sum[WIDTH];
                            commit    = 1'b1;
                        end
                        OP_SUB: begin
                            result_d  = sub_diff[WIDTH-1:0];
                            new_carry = sub_diff[WIDTH];
                            commit    = 1'b1;
                        end
                        OP_AND: begin
                            result_d = a & b;
                            commit   = 1'b1;
                        end
                        OP_OR: begin
                            result_d = a | b;
                            commit   = 1'b1;
                        end
                        OP_XOR: begin
                            result_d = a ^ b;
                            commit   = 1'b1;
                        end
                        OP_LSH, OP_RSH: begin
                            work_d = a;
                            rem_d  = {1'b0, amt};
                            shl_d  = (op == OP_LSH);
                            if (amt == '0) begin
                                result_d = a;
                                commit   = 1'b1;
                            end
                        end
                        OP_SEQ: begin
                            result_d = {{(WIDTH-1){1'b0}}, (a == b)};
                            commit   = 1'b1;
                        end
                        OP_SLT: begin
                            result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                            commit   = 1'b1;
                        end
                        OP_MUL: begin
                            work_d   = a;
                            mplier_d = b;
                            acc_d    = '0;
                            rem_d    = MUL_CYCLES;
                        end
                        default: begin
                            result_d    = '0;
                            new_illegal = 1'b1;
                            commit      = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                work_d = shl_q ? (work_q << step) : (work_q >> step);
                rem_d  = rem_q - step;
                if (rem_d == '0) begin
                    result_d = work_d;
                    commit   = 1'b1;
                end
            end
            MUL: begin
                // work_q holds the multiplicand shifted into place for the current multiplier bit
                acc_d    = mplier_q[0] ? (acc_q + work_q) : acc_q;
                work_d   = work_q << 1;
                mplier_d = mplier_q >> 1;
                rem_d    = rem_q - ONE;
                if (rem_d == '0) begin
                    result_d = acc_d;
                    commit   = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (commit) begin
            carry_d   = new_carry;
            illegal_d = new_illegal;
            zero_d    = (result_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q    <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            shl_q     <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            work_q    <= work_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            shl_q     <= shl_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: two instances (SHIFT_STEP 1 and 2) driven in lockstep, checked
// against a table of known vectors, hand-written handshake/reset sequences and random ops.
module tb_alu_iter;

    localparam int W     = 8;
    localparam int STEP2 = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         in_ready1, out_valid1, carry1, zero1, illegal1;
    logic [W-1:0] result1;
    logic         in_ready2, out_valid2, carry2, zero2, illegal2;
    logic [W-1:0] result2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(W), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .carry(carry1), .zero(zero1), .illegal(illegal1)
    );

    alu_iter #(.WIDTH(W), .SHIFT_STEP(STEP2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .carry(carry2), .zero(zero2), .illegal(illegal2)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       il;
        int         lat1;
        int         lat2;
    } vec_t;

    typedef struct {
        int res1, c1, z1, il1, lat1;
        int res2, z2, lat2;
        int pulses1, busy_ready1;
    } obs_t;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model written from the arithmetic rules, not from the RTL structure
    function automatic void ref_model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                      output logic [7:0] res, output logic c, output logic z,
                                      output logic il, output int lat1, output int lat2);
        int ua, ub, amt, t, sa, sb;
        ua = int'(x);
        ub = int'(y);
        amt = ub % 8;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 1'b0; il = 1'b0; lat1 = 1; lat2 = 1; t = 0;
        case (o)
            4'h0: begin t = ua + ub; c = (t > 255); end
            4'h1: begin t = ua - ub + 256; c = (ua < ub); end
            4'h2: t = ua & ub;
            4'h3: t = ua | ub;
            4'h4: t = ua ^ ub;
            4'h5: begin t = ua * (2 ** amt); lat1 = 1 + amt; lat2 = 1 + (amt + STEP2 - 1) / STEP2; end
            4'h6: begin t = ua / (2 ** amt); lat1 = 1 + amt; lat2 = 1 + (amt + STEP2 - 1) / STEP2; end
            4'h7: t = (ua == ub) ? 1 : 0;
            4'h8: t = (sa < sb) ? 1 : 0;
            4'h9: begin t = ua * ub; lat1 = W + 1; lat2 = W + 1; end
            default: begin t = 0; il = 1'b1; end
        endcase
        res = 8'(t % 256);
        z = (res == 8'h00);
    endfunction

    task automatic waitIdle();
        int g;
        g = 0;
        @(negedge clk);
        while (!(in_ready1 && in_ready2) && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            checkOutput("idle_timeout", 0, 1);
        end
    endtask

    // Presents one op for a single accepting cycle, scrambles inputs afterwards, and
    // records when and what each instance produced
    task automatic applyStimulus(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                 output obs_t r);
        int hi;
        waitIdle();
        op = o; a = x; b = y; in_valid = 1'b1;
        r = '{default: 0};
        r.lat1 = -1;
        r.lat2 = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (out_valid1) begin
                r.pulses1++;
                if (r.lat1 < 0) begin
                    r.lat1 = cyc; r.res1 = int'(result1); r.c1 = int'(carry1);
                    r.z1 = int'(zero1); r.il1 = int'(illegal1);
                end
            end else if (r.lat1 < 0 && in_ready1) begin
                r.busy_ready1++;
            end
            if (out_valid2 && r.lat2 < 0) begin
                r.lat2 = cyc; r.res2 = int'(result2); r.z2 = int'(zero2);
            end
            if (cyc == 1) begin
                in_valid = 1'b0;
                op = 4'($urandom_range(0, 15));
                a = 8'($urandom);
                b = 8'($urandom);
            end
            hi = (r.lat1 > r.lat2) ? r.lat1 : r.lat2;
            if (r.lat1 >= 0 && r.lat2 >= 0 && cyc >= hi + 1) break;
        end
    endtask

    task automatic runCheck(input string name, input logic [3:0] o, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] er, input logic ec,
                            input logic ez, input logic ei, input int el1, input int el2);
        obs_t r;
        applyStimulus(o, x, y, r);
        checkOutput({name, ".res"},    r.res1, int'(er));
        checkOutput({name, ".carry"},  r.c1,   int'(ec));
        checkOutput({name, ".zero"},   r.z1,   int'(ez));
        checkOutput({name, ".ill"},    r.il1,  int'(ei));
        checkOutput({name, ".lat"},    r.lat1, el1);
        checkOutput({name, ".res2"},   r.res2, int'(er));
        checkOutput({name, ".zero2"},  r.z2,   int'(ez));
        checkOutput({name, ".lat2"},   r.lat2, el2);
        checkOutput({name, ".pulse"},  r.pulses1, 1);
        checkOutput({name, ".busyrdy"}, r.busy_ready1, 0);
    endtask

    vec_t vecs[17];

    initial begin
        logic [7:0] er;
        logic       ec, ez, ei;
        int         el1, el2;
        logic [3:0] ro;
        logic [7:0] ra, rb;
        logic [7:0] held;

        vecs[0]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1};
        vecs[1]  = '{4'h5, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4, 3};
        vecs[2]  = '{4'h5, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[3]  = '{4'h5, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 4, 3};
        vecs[4]  = '{4'h6, 8'h81, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 8, 5};
        vecs[5]  = '{4'h9, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 9, 9};
        vecs[6]  = '{4'h9, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 9, 9};
        vecs[7]  = '{4'h8, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[8]  = '{4'h8, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1};
        vecs[9]  = '{4'h1, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1, 1};
        vecs[10] = '{4'h1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1};
        vecs[11] = '{4'h7, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[12] = '{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[13] = '{4'h4, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1};
        vecs[14] = '{4'hC, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 1, 1};
        vecs[15] = '{4'h5, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 8, 5};
        vecs[16] = '{4'h3, 8'h12, 8'h03, 8'h13, 1'b0, 1'b0, 1'b0, 1, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'h0; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst.in_ready",  int'(in_ready1),  1);
        checkOutput("rst.out_valid", int'(out_valid1), 0);
        checkOutput("rst.result",    int'(result1),    0);
        checkOutput("rst.carry",     int'(carry1),     0);
        checkOutput("rst.zero",      int'(zero1),      0);
        checkOutput("rst.illegal",   int'(illegal1),   0);
        rst_n = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 17; i++) begin
            runCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                     vecs[i].c, vecs[i].z, vecs[i].il, vecs[i].lat1, vecs[i].lat2);
        end

        $display("[TB] backpressure");
        waitIdle();
        out_ready = 1'b0;
        op = 4'h0; a = 8'hF0; b = 8'h20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp.valid", int'(out_valid1), 1);
        held = result1;
        checkOutput("bp.result", int'(held), 8'h10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp.hold%0d.valid", k), int'(out_valid1), 1);
            checkOutput($sformatf("bp.hold%0d.result", k), int'(result1), 8'h10);
            checkOutput($sformatf("bp.hold%0d.carry", k), int'(carry1), 1);
            checkOutput($sformatf("bp.hold%0d.zero", k), int'(zero1), 0);
            checkOutput($sformatf("bp.hold%0d.in_ready", k), int'(in_ready1), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp.release.valid", int'(out_valid1), 0);
        checkOutput("bp.release.in_ready", int'(in_ready1), 1);

        $display("[TB] reset during MUL");
        runCheck("pre_rst_add", 4'h0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 1, 1);
        waitIdle();
        op = 4'h9; a = 8'd13; b = 8'd11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mrst.out_valid", int'(out_valid1), 0);
        checkOutput("mrst.result",    int'(result1),    0);
        checkOutput("mrst.in_ready",  int'(in_ready1),  1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mrst.after.valid", int'(out_valid1), 0);
        runCheck("post_rst_add", 4'h0, 8'd20, 8'd22, 8'd42, 1'b0, 1'b0, 1'b0, 1, 1);

        $display("[TB] random ops");
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = 8'($urandom);
            ref_model(ro, ra, rb, er, ec, ez, ei, el1, el2);
            runCheck($sformatf("rnd%0d_op%0h", i, ro), ro, ra, rb, er, ec, ez, ei, el1, el2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
